// File: rtl/dma_bus_arbiter.sv
// DMA bus arbiter, CPU side of the DMA request/grant handshake.
// Waits for the CPU's in-flight access to finish, grants the bus for one
// block burst, counts memory acks, then withdraws the grant. Before the next
// grant the CPU gets a fairness gap. A grant that stops receiving acks is
// force-released, and that event is latched in a sticky error flag.
module dma_bus_arbiter #(
    parameter int WORD_SIZE   = 16,
    parameter int BURST_WORDS = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 br_i,
    input  logic                 cpu_mem_busy_i,
    input  logic                 mem_ack_i,
    output logic                 bg_o,
    output logic                 cpu_stall_o,
    output logic [WORD_SIZE-1:0] words_done_o,
    output logic [WORD_SIZE-1:0] grant_count_o,
    output logic                 dma_end_o,
    output logic                 timeout_err_o
);

    // Wide enough to hold ACK_TIMEOUT itself; the grant is released on
    // reaching it, so the counter never wraps.
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_GRANT,
        S_RELEASE,
        S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic                 bg_q, bg_d;
    logic                 stall_q, stall_d;
    logic [WORD_SIZE-1:0] words_q, words_d;
    logic [WORD_SIZE-1:0] grant_count_q, grant_count_d;
    logic                 dma_end_q, dma_end_d;
    logic                 tmo_err_q, tmo_err_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d       = state_q;
        words_d       = words_q;
        grant_count_d = grant_count_q;
        tmo_d         = tmo_q;
        tmo_err_d     = tmo_err_q;
        dma_end_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (br_i) begin
                    state_d = cpu_mem_busy_i ? S_WAIT : S_GRANT;
                end
            end
            S_WAIT: begin
                if (!br_i) begin
                    state_d = S_IDLE;
                end else if (!cpu_mem_busy_i) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (mem_ack_i) begin
                    words_d = words_q + 1'b1;
                    tmo_d   = '0;
                end else begin
                    tmo_d   = tmo_q + 1'b1;
                end
                // Completion and abort both win over a coincident timeout.
                if ((mem_ack_i && (words_d == WORD_SIZE'(BURST_WORDS))) || !br_i) begin
                    state_d = S_RELEASE;
                end else if (!mem_ack_i && (tmo_d == TMO_W'(ACK_TIMEOUT))) begin
                    state_d   = S_RELEASE;
                    tmo_err_d = 1'b1;
                end
            end
            S_RELEASE: begin
                state_d = S_GAP;
            end
            S_GAP: begin
                // br is not a grant trigger here; it only decides dma_end.
                state_d   = S_IDLE;
                dma_end_d = !br_i;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Grant entry: fresh burst bookkeeping, one more grant issued.
        if ((state_q != S_GRANT) && (state_d == S_GRANT)) begin
            words_d       = '0;
            tmo_d         = '0;
            grant_count_d = grant_count_q + 1'b1;
        end

        bg_d    = (state_d == S_GRANT);
        stall_d = (state_d inside {S_WAIT, S_GRANT, S_RELEASE});
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            bg_q          <= 1'b0;
            stall_q       <= 1'b0;
            words_q       <= '0;
            grant_count_q <= '0;
            dma_end_q     <= 1'b0;
            tmo_err_q     <= 1'b0;
            tmo_q         <= '0;
        end else begin
            state_q       <= state_d;
            bg_q          <= bg_d;
            stall_q       <= stall_d;
            words_q       <= words_d;
            grant_count_q <= grant_count_d;
            dma_end_q     <= dma_end_d;
            tmo_err_q     <= tmo_err_d;
            tmo_q         <= tmo_d;
        end
    end

    assign bg_o          = bg_q;
    assign cpu_stall_o   = stall_q;
    assign words_done_o  = words_q;
    assign grant_count_o = grant_count_q;
    assign dma_end_o     = dma_end_q;
    assign timeout_err_o = tmo_err_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter: one task per scenario, inline checks.
module tb_dma_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        br;
    logic        cpu_mem_busy;
    logic        mem_ack;
    logic        bg;
    logic        cpu_stall;
    logic [15:0] words_done;
    logic [15:0] grant_count;
    logic        dma_end;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    dma_bus_arbiter #(
        .WORD_SIZE  (16),
        .BURST_WORDS(4),
        .ACK_TIMEOUT(64)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .br_i          (br),
        .cpu_mem_busy_i(cpu_mem_busy),
        .mem_ack_i     (mem_ack),
        .bg_o          (bg),
        .cpu_stall_o   (cpu_stall),
        .words_done_o  (words_done),
        .grant_count_o (grant_count),
        .dma_end_o     (dma_end),
        .timeout_err_o (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        br = 1'b0;
        cpu_mem_busy = 1'b0;
        mem_ack = 1'b0;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (bg !== 1'b0) begin errors++; $display("FAIL reset_bg got %0b exp 0", bg); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", cpu_stall); end
        checks++; if (words_done !== 16'd0) begin errors++; $display("FAIL reset_words got %0d exp 0", words_done); end
        checks++; if (grant_count !== 16'd0) begin errors++; $display("FAIL reset_gcnt got %0d exp 0", grant_count); end
        checks++; if (dma_end !== 1'b0) begin errors++; $display("FAIL reset_dma_end got %0b exp 0", dma_end); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_tmo_err got %0b exp 0", timeout_err); end
    endtask

    task automatic test_single_block;
        int hi;
        do_reset;
        br = 1'b1;
        tick;   // IDLE -> GRANT
        checks++; if (bg !== 1'b1) begin errors++; $display("FAIL single_bg_rise got %0b exp 1", bg); end
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL single_stall got %0b exp 1", cpu_stall); end
        checks++; if (grant_count !== 16'd1) begin errors++; $display("FAIL single_gcnt got %0d exp 1", grant_count); end
        hi = bg ? 1 : 0;
        tick;   // memory answers one cycle after it sees the grant
        if (bg) hi++;
        mem_ack = 1'b1;
        repeat (4) begin
            tick;
            if (bg) hi++;
        end
        mem_ack = 1'b0;
        br = 1'b0;
        checks++; if (hi !== 5) begin errors++; $display("FAIL single_bg_cycles got %0d exp 5", hi); end
        checks++; if (words_done !== 16'd4) begin errors++; $display("FAIL single_words got %0d exp 4", words_done); end
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL single_release_stall got %0b exp 1", cpu_stall); end
        tick;   // RELEASE -> GAP
        checks++; if (cpu_stall !== 1'b0 || bg !== 1'b0) begin errors++; $display("FAIL single_gap got stall=%0b bg=%0b exp 0 0", cpu_stall, bg); end
        checks++; if (dma_end !== 1'b0) begin errors++; $display("FAIL single_dma_end_early got %0b exp 0", dma_end); end
        tick;   // GAP -> IDLE, br was 0 in GAP
        checks++; if (dma_end !== 1'b1) begin errors++; $display("FAIL single_dma_end got %0b exp 1", dma_end); end
        tick;
        checks++; if (dma_end !== 1'b0) begin errors++; $display("FAIL single_dma_end_pulse got %0b exp 0", dma_end); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL single_tmo_err got %0b exp 0", timeout_err); end
        checks++; if (words_done !== 16'd4) begin errors++; $display("FAIL single_words_hold got %0d exp 4", words_done); end
    endtask

    task automatic test_cpu_busy;
        do_reset;
        br = 1'b1;
        cpu_mem_busy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            checks++; if (cpu_stall !== 1'b1 || bg !== 1'b0) begin errors++; $display("FAIL busy_wait%0d got stall=%0b bg=%0b exp 1 0", c, cpu_stall, bg); end
        end
        cpu_mem_busy = 1'b0;
        tick;   // WAIT -> GRANT
        checks++; if (bg !== 1'b1) begin errors++; $display("FAIL busy_grant got %0b exp 1", bg); end
        br = 1'b0;  // abort with no acks
        tick;
        checks++; if (bg !== 1'b0 || words_done !== 16'd0) begin errors++; $display("FAIL busy_abort got bg=%0b words=%0d exp 0 0", bg, words_done); end
        tick;
        tick;
        checks++; if (dma_end !== 1'b1) begin errors++; $display("FAIL busy_dma_end got %0b exp 1", dma_end); end
        // Request withdrawn while still waiting: back to IDLE, no dma_end.
        br = 1'b1;
        cpu_mem_busy = 1'b1;
        tick;
        br = 1'b0;
        tick;
        checks++; if (cpu_stall !== 1'b0 || bg !== 1'b0) begin errors++; $display("FAIL wait_drop got stall=%0b bg=%0b exp 0 0", cpu_stall, bg); end
        tick;
        checks++; if (dma_end !== 1'b0) begin errors++; $display("FAIL wait_drop_dma_end got %0b exp 0", dma_end); end
        checks++; if (grant_count !== 16'd1) begin errors++; $display("FAIL wait_drop_gcnt got %0d exp 1", grant_count); end
        cpu_mem_busy = 1'b0;
    endtask

    task automatic test_multi_block;
        int   rises, falls, low_run, stall0_run, ends, early_end;
        logic prev_bg;
        do_reset;
        rises = 0; falls = 0; low_run = 0; stall0_run = 0; ends = 0; early_end = 0;
        prev_bg = 1'b0;
        br = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tick;
            if (bg && !prev_bg) begin
                rises++;
                if (rises > 1) begin
                    // Fall at edge k, GAP k+1, IDLE k+2, re-grant at k+3.
                    checks++; if (low_run !== 3) begin errors++; $display("FAIL multi_gap_bg_low got %0d exp 3", low_run); end
                    checks++; if (stall0_run !== 2) begin errors++; $display("FAIL multi_gap_stall_low got %0d exp 2", stall0_run); end
                end
            end
            if (!bg && prev_bg) begin
                falls++;
                low_run = 0;
                stall0_run = 0;
                if (falls == 3) br = 1'b0;
            end
            if (!bg) begin
                low_run++;
                if (!cpu_stall) stall0_run++;
            end
            if (dma_end) begin
                ends++;
                if (falls < 3) early_end++;
            end
            mem_ack = bg;
            prev_bg = bg;
        end
        mem_ack = 1'b0;
        checks++; if (rises !== 3) begin errors++; $display("FAIL multi_grants got %0d exp 3", rises); end
        checks++; if (grant_count !== 16'd3) begin errors++; $display("FAIL multi_gcnt got %0d exp 3", grant_count); end
        checks++; if (ends !== 1 || early_end !== 0) begin errors++; $display("FAIL multi_dma_end got %0d early %0d exp 1 0", ends, early_end); end
        checks++; if (words_done !== 16'd4) begin errors++; $display("FAIL multi_words got %0d exp 4", words_done); end
    endtask

    task automatic test_timeout;
        int   hi;
        logic early_err;
        do_reset;
        br = 1'b1;
        hi = 0;
        early_err = 1'b0;
        tick;   // GRANT entry
        for (int c = 0; c < 100 && bg; c++) begin
            hi++;
            if (timeout_err) early_err = 1'b1;
            tick;
        end
        checks++; if (hi !== 64) begin errors++; $display("FAIL tmo_grant_cycles got %0d exp 64", hi); end
        checks++; if (bg !== 1'b0) begin errors++; $display("FAIL tmo_bg got %0b exp 0", bg); end
        checks++; if (early_err !== 1'b0) begin errors++; $display("FAIL tmo_err_early got %0b exp 0", early_err); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_err got %0b exp 1", timeout_err); end
        checks++; if (words_done !== 16'd0) begin errors++; $display("FAIL tmo_words got %0d exp 0", words_done); end
        br = 1'b0;
        repeat (4) tick;
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky got %0b exp 1", timeout_err); end
        do_reset;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_err_clear got %0b exp 0", timeout_err); end
    endtask

    task automatic test_abort_reset;
        int ends;
        do_reset;
        br = 1'b1;
        tick;
        mem_ack = 1'b1;
        tick;
        tick;
        mem_ack = 1'b0;
        br = 1'b0;
        tick;   // abort -> RELEASE
        checks++; if (bg !== 1'b0 || cpu_stall !== 1'b1) begin errors++; $display("FAIL abort_release got bg=%0b stall=%0b exp 0 1", bg, cpu_stall); end
        checks++; if (words_done !== 16'd2) begin errors++; $display("FAIL abort_words got %0d exp 2", words_done); end
        tick;
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL abort_gap_stall got %0b exp 0", cpu_stall); end
        tick;
        checks++; if (dma_end !== 1'b1) begin errors++; $display("FAIL abort_dma_end got %0b exp 1", dma_end); end
        // Reset in the middle of a grant.
        br = 1'b1;
        tick;
        mem_ack = 1'b1;
        tick;
        reset = 1'b1;
        mem_ack = 1'b0;
        br = 1'b0;
        tick;
        reset = 1'b0;
        checks++; if (bg !== 1'b0 || cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_grant got bg=%0b stall=%0b exp 0 0", bg, cpu_stall); end
        checks++; if (words_done !== 16'd0 || grant_count !== 16'd0) begin errors++; $display("FAIL rst_counters got words=%0d gcnt=%0d exp 0 0", words_done, grant_count); end
        ends = dma_end ? 1 : 0;
        repeat (3) begin
            tick;
            if (dma_end) ends++;
        end
        checks++; if (ends !== 0) begin errors++; $display("FAIL rst_dma_end got %0d exp 0", ends); end
    endtask

    task automatic test_spurious_wrap;
        do_reset;
        br = 1'b1;
        tick;
        mem_ack = 1'b1;
        repeat (3) tick;
        mem_ack = 1'b0;
        br = 1'b0;
        repeat (3) tick;   // RELEASE, GAP, IDLE
        mem_ack = 1'b1;
        repeat (4) tick;
        mem_ack = 1'b0;
        checks++; if (words_done !== 16'd3) begin errors++; $display("FAIL spurious_words got %0d exp 3", words_done); end
        checks++; if (bg !== 1'b0) begin errors++; $display("FAIL spurious_bg got %0b exp 0", bg); end
        // Preload the grant counter to the top of its range.
        force dut.grant_count_q = 16'hFFFF;
        #2;
        release dut.grant_count_q;
        #2;
        checks++; if (grant_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got %h exp ffff", grant_count); end
        br = 1'b1;
        tick;
        checks++; if (grant_count !== 16'h0000) begin errors++; $display("FAIL wrap_gcnt got %h exp 0000", grant_count); end
        checks++; if (bg !== 1'b1 || words_done !== 16'd0) begin errors++; $display("FAIL wrap_entry got bg=%0b words=%0d exp 1 0", bg, words_done); end
        br = 1'b0;
        repeat (3) tick;
    endtask

    initial begin
        reset = 1'b1;
        br = 1'b0;
        cpu_mem_busy = 1'b0;
        mem_ack = 1'b0;
        test_reset;
        test_single_block;
        test_cpu_busy;
        test_multi_block;
        test_timeout;
        test_abort_reset;
        test_spurious_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
